// File: rtl/add_round_key_seq.sv
// add_round_key_seq: AddRoundKey stage with a stored key schedule and valid/ready flow.
// Define ARK_ZEROIZE_EN to add a zeroize input that wipes the schedule.
module add_round_key_seq #(
  parameter int NK = 8
) (
  input  logic         clk,
  input  logic         reset,
`ifdef ARK_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_load,
  input  logic         key_wr_valid,
  input  logic [31:0]  key_wr_data,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_err
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int AW = $clog2(NW);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
`ifdef ARK_ZEROIZE_EN
  localparam logic [1:0] ST_ZERO  = 2'd3;
`endif

  logic [1:0]    st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   sched_q [NW];

  logic          out_valid_q, out_valid_d;
  logic [127:0]  out_state_q, out_state_d;
  logic [3:0]    out_round_q, out_round_d;
  logic          out_err_q, out_err_d;

  logic          in_fire;
  logic          round_ok;
  logic [AW-1:0] rd_base;
  logic [127:0]  rk;

  assign cnt_last = (cnt_q == AW'(NW - 1));

  // Schedule load / wipe sequencing
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_data = key_wr_data;
    case (st_q)
      ST_EMPTY: begin
        if (key_load) begin
          st_d  = ST_LOAD;
          cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (key_load) begin
          cnt_d = '0;
        end else if (key_wr_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + AW'(1);
          if (cnt_last) begin
            st_d  = ST_READY;
            cnt_d = '0;
          end
        end
      end
      ST_READY: begin
        if (key_load) begin
          st_d  = ST_LOAD;
          cnt_d = '0;
        end
      end
`ifdef ARK_ZEROIZE_EN
      ST_ZERO: begin
        wr_en   = 1'b1;
        wr_data = '0;
        cnt_d   = cnt_q + AW'(1);
        if (cnt_last) begin
          st_d  = ST_EMPTY;
          cnt_d = '0;
        end
      end
`endif
      default: begin
        st_d  = ST_EMPTY;
        cnt_d = '0;
      end
    endcase
`ifdef ARK_ZEROIZE_EN
    if (zeroize) begin
      st_d  = ST_ZERO;
      cnt_d = '0;
      wr_en = 1'b0;
    end
`endif
  end

  assign key_ready = (st_q == ST_READY);
  assign in_ready  = key_ready & (~out_valid_q | out_ready);
  assign in_fire   = in_valid & in_ready;
  assign round_ok  = (in_round <= 4'(NR));

  // Out-of-range rounds read word 0 but the key is masked off below
  always_comb begin
    rd_base = '0;
    if (round_ok) rd_base = AW'({in_round, 2'b00});
    rk = {sched_q[rd_base],
          sched_q[rd_base + AW'(1)],
          sched_q[rd_base + AW'(2)],
          sched_q[rd_base + AW'(3)]};
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;
    out_round_d = out_round_q;
    out_err_d   = out_err_q;
    if (in_fire) begin
      out_valid_d = 1'b1;
      out_state_d = round_ok ? (in_state ^ rk) : in_state;
      out_round_d = in_round;
      out_err_d   = ~round_ok;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef ARK_ZEROIZE_EN
    if (zeroize) begin
      out_valid_d = 1'b0;
      out_state_d = '0;
      out_round_d = '0;
      out_err_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= ST_EMPTY;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_round_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
      out_round_q <= out_round_d;
      out_err_q   <= out_err_d;
    end
  end

  // Schedule store is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) sched_q[wr_addr] <= wr_data;
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_round = out_round_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_add_round_key_seq.sv
// Self-checking bench for add_round_key_seq (NK=4) against a schedule-array model.
// Exercises the zeroize path when ARK_ZEROIZE_EN is defined.
module tb_add_round_key_seq;

  localparam int NK = 4;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  logic         clk = 1'b0;
  logic         reset;
`ifdef ARK_ZEROIZE_EN
  logic         zeroize;
`endif
  logic         key_load;
  logic         key_wr_valid;
  logic [31:0]  key_wr_data;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [3:0]   in_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_err;

  int errs = 0;
  int checks = 0;
  logic [31:0] mw [NW];

  always #5 clk = ~clk;

  add_round_key_seq #(.NK(NK)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef ARK_ZEROIZE_EN
    .zeroize      (zeroize),
`endif
    .key_load     (key_load),
    .key_wr_valid (key_wr_valid),
    .key_wr_data  (key_wr_data),
    .key_ready    (key_ready),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_state     (in_state),
    .in_round     (in_round),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_state    (out_state),
    .out_round    (out_round),
    .out_err      (out_err)
  );

  // Model: error flag in bit 128, result state below
  function automatic logic [128:0] ref_ark(input logic [127:0] s,
                                           input logic [3:0] r);
    logic [127:0] k;
    int b;
    if (r > NR) return {1'b1, s};
    b = 4 * int'(r);
    k = {mw[b], mw[b+1], mw[b+2], mw[b+3]};
    return {1'b0, s ^ k};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic full_load();
    key_load = 1'b1;
    cyc();
    key_load = 1'b0;
    for (int i = 0; i < NW; i++) begin
      key_wr_valid = 1'b1;
      key_wr_data  = mw[i];
      cyc();
    end
    key_wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_load = 1'b0;
    key_wr_valid = 1'b0;
    key_wr_data = '0;
    in_valid = 1'b0;
    in_state = '0;
    in_round = '0;
    out_ready = 1'b0;
`ifdef ARK_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    checks++; if (key_ready !== 1'b0) begin errs++; $display("FAIL reset_key_ready got %b want 0", key_ready); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_state !== 128'h0) begin errs++; $display("FAIL reset_out_state got %h want 0", out_state); end
    checks++; if (out_round !== 4'h0) begin errs++; $display("FAIL reset_out_round got %h want 0", out_round); end
    checks++; if (out_err !== 1'b0) begin errs++; $display("FAIL reset_out_err got %b want 0", out_err); end
  endtask

  task automatic test_key_load();
    mw[0] = 32'h00010203;
    mw[1] = 32'h04050607;
    mw[2] = 32'h08090a0b;
    mw[3] = 32'h0c0d0e0f;
    for (int i = 4; i < NW; i++) mw[i] = $urandom;
    key_load = 1'b1;
    cyc();
    key_load = 1'b0;
    for (int i = 0; i < NW; i++) begin
      key_wr_valid = 1'b1;
      key_wr_data  = mw[i];
      #1;
      if (i == 0 || i == NW - 1) begin
        checks++;
        if (key_ready !== 1'b0) begin errs++; $display("FAIL load_not_ready word %0d got %b want 0", i, key_ready); end
      end
      @(posedge clk);
      #1;
    end
    key_wr_valid = 1'b0;
    checks++; if (key_ready !== 1'b1) begin errs++; $display("FAIL load_ready got %b want 1", key_ready); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = 128'h00112233445566778899aabbccddeeff;
    in_round  = 4'd0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL kat_in_ready got %b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL kat_valid got %b want 1", out_valid); end
    checks++;
    if (out_state !== 128'h00102030405060708090a0b0c0d0e0f0) begin
      errs++;
      $display("FAIL kat_state got %h want 00102030405060708090a0b0c0d0e0f0", out_state);
    end
    checks++; if (out_err !== 1'b0) begin errs++; $display("FAIL kat_err got %b want 0", out_err); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL kat_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [128:0] e;
    out_ready = 1'b1;
    for (int r = 0; r <= NR; r++) begin
      in_valid = 1'b1;
      in_state = rnd128();
      in_round = 4'(r);
      e = ref_ark(in_state, in_round);
      #1;
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready r=%0d got %b want 1", r, in_ready); end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_state !== e[127:0] || out_round !== 4'(r)) begin
        errs++;
        $display("FAIL b2b r=%0d got v=%b %h rd=%0d want v=1 %h rd=%0d",
                 r, out_valid, out_state, out_round, e[127:0], r);
      end
    end
    in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [128:0] e0, e1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_state  = rnd128();
    in_round  = 4'd3;
    e0 = ref_ark(in_state, in_round);
    cyc();
    out_ready = 1'b0;
    in_state  = rnd128();
    in_round  = 4'd7;
    e1 = ref_ark(in_state, in_round);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_state !== e0[127:0] || out_round !== 4'd3) begin
        errs++;
        $display("FAIL bp_hold cyc %0d got v=%b %h rd=%0d want v=1 %h rd=3",
                 i, out_valid, out_state, out_round, e0[127:0]);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release got %b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_state !== e1[127:0] || out_round !== 4'd7) begin
      errs++;
      $display("FAIL bp_next got v=%b %h rd=%0d want v=1 %h rd=7",
               out_valid, out_state, out_round, e1[127:0]);
    end
    cyc();
  endtask

  task automatic test_bad_round();
    logic [128:0] e;
    out_ready = 1'b1;
    for (int r = NR + 1; r < 16; r++) begin
      in_valid = 1'b1;
      in_state = rnd128();
      in_round = 4'(r);
      e = ref_ark(in_state, in_round);
      cyc();
      checks++;
      if (out_err !== e[128] || out_state !== e[127:0] || out_valid !== 1'b1) begin
        errs++;
        $display("FAIL bad_round r=%0d got err=%b %h want err=%b %h",
                 r, out_err, out_state, e[128], e[127:0]);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reload();
    logic [128:0] e;
    out_ready = 1'b1;
    key_load  = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rl_inready_pre got %b want 1", in_ready); end
    cyc();
    key_load = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rl_inready_post got %b want 0", in_ready); end
    for (int i = 0; i < 20; i++) begin
      key_wr_valid = 1'b1;
      key_wr_data  = $urandom;
      cyc();
    end
    key_load    = 1'b1;
    key_wr_data = 32'hdeadbeef;
    cyc();
    key_load = 1'b0;
    for (int i = 0; i < NW; i++) mw[i] = $urandom;
    for (int i = 0; i < NW; i++) begin
      key_wr_valid = 1'b1;
      key_wr_data  = mw[i];
      #1;
      if (i == 20 || i == NW - 1) begin
        checks++;
        if (key_ready !== 1'b0) begin errs++; $display("FAIL rl_early word %0d got %b want 0", i, key_ready); end
      end
      @(posedge clk);
      #1;
    end
    checks++; if (key_ready !== 1'b1) begin errs++; $display("FAIL rl_ready got %b want 1", key_ready); end
    for (int i = 0; i < 4; i++) begin
      key_wr_data = $urandom;
      cyc();
    end
    key_wr_valid = 1'b0;
    for (int r = 0; r <= NR; r += 2) begin
      in_valid = 1'b1;
      in_state = rnd128();
      in_round = 4'(r);
      e = ref_ark(in_state, in_round);
      cyc();
      checks++;
      if (out_state !== e[127:0] || out_err !== 1'b0) begin
        errs++;
        $display("FAIL rl_result r=%0d got %h want %h", r, out_state, e[127:0]);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = rnd128();
    in_round  = 4'd2;
    cyc();
    in_valid = 1'b0;
    key_load = 1'b1;
    cyc();
    key_load = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || key_ready !== 1'b0) begin
      errs++;
      $display("FAIL rm_pending got v=%b kr=%b want v=1 kr=0", out_valid, key_ready);
    end
    for (int i = 0; i < 10; i++) begin
      key_wr_valid = 1'b1;
      key_wr_data  = $urandom;
      cyc();
    end
    key_wr_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_state !== 128'h0 || out_round !== 4'h0 ||
        out_err !== 1'b0 || key_ready !== 1'b0 || in_ready !== 1'b0) begin
      errs++;
      $display("FAIL rm_async got v=%b s=%h rd=%h e=%b kr=%b ir=%b want all 0",
               out_valid, out_state, out_round, out_err, key_ready, in_ready);
    end
    cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    cyc();
    for (int i = 0; i < NW; i++) mw[i] = $urandom;
    full_load();
    checks++; if (key_ready !== 1'b1) begin errs++; $display("FAIL rm_reload got %b want 1", key_ready); end
  endtask

`ifdef ARK_ZEROIZE_EN
  task automatic test_zeroize();
    logic [127:0] s;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = rnd128();
    in_round  = 4'd1;
    cyc();
    in_valid = 1'b0;
    zeroize  = 1'b1;
    key_load = 1'b1;
    cyc();
    zeroize  = 1'b0;
    key_load = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_state !== 128'h0) begin
      errs++;
      $display("FAIL zz_clear got v=%b s=%h want v=0 s=0", out_valid, out_state);
    end
    for (int i = 0; i < NW; i++) begin
      key_load = (i == 10);
      checks++;
      if (key_ready !== 1'b0) begin errs++; $display("FAIL zz_busy cyc %0d got %b want 0", i, key_ready); end
      cyc();
    end
    key_load = 1'b0;
    key_wr_valid = 1'b1;
    key_wr_data  = 32'h12345678;
    cyc();
    key_wr_valid = 1'b0;
    checks++; if (key_ready !== 1'b0) begin errs++; $display("FAIL zz_empty got %b want 0", key_ready); end
    for (int i = 0; i < NW; i++) mw[i] = '0;
    full_load();
    out_ready = 1'b1;
    s = rnd128();
    in_valid = 1'b1;
    in_state = s;
    in_round = 4'd5;
    cyc();
    in_valid = 1'b0;
    checks++; if (out_state !== s) begin errs++; $display("FAIL zz_round5 got %h want %h", out_state, s); end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_key_load();
    test_back_to_back();
    test_backpressure();
    test_bad_round();
    test_reload();
    test_reset_mid();
`ifdef ARK_ZEROIZE_EN
    test_zeroize();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
